b230213cs_aswin_1_adder: RTL and testbench

- Registered 8-bit binary adder with carry-in and carry-out.
- Operands are combined in a carry-lookahead adder built from two 4-bit CLA groups, with group carry chained low-to-high.
- The sum and carry are captured in output registers.
- Used as a leaf arithmetic block wherever a clocked A+B+Cin result with one cycle of latency is needed.

---
 rtl/b230213cs_aswin_1_adder.sv | 67 ++++++
 tb/tb_b230213cs_aswin_1_adder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/b230213cs_aswin_1_adder.sv
// Registered WIDTH-bit adder: {Cout,S} = A + B + Cin, one cycle of latency.
// Carries are formed by 4-bit carry-lookahead groups chained low-to-high.
module b230213cs_aswin_1_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             out_valid
);

  localparam int NGRP = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [WIDTH-1:0] sum;

  assign g = A & B;
  assign p = A ^ B;

  // Inner carries c1..c3 use full lookahead; the group carry-out is taken from
  // the group generate/propagate pair so the chain between groups is one level.
  always_comb begin
    c     = '0;
    grp_g = '0;
    grp_p = '0;
    c[0]  = Cin;
    for (int unsigned k = 0; k < NGRP; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      grp_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      c[4*k+4] = grp_g[k] | (grp_p[k] & c[4*k]);
    end
  end

  assign sum = p ^ c[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S         <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= sum;
        Cout <= c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_b230213cs_aswin_1_adder.sv
// Self-checking bench for b230213cs_aswin_1_adder: directed vectors, hold,
// asynchronous reset, and randomized traffic against an arithmetic model.
module tb_b230213cs_aswin_1_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] S;
  logic       Cout;
  logic       out_valid;

  int unsigned n_cmp;
  int unsigned n_bad;

  b230213cs_aswin_1_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .S         (S),
    .Cout      (Cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
    @(negedge clk);
    A = a; B = b; Cin = c; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  vec_t       vecs[8];
  logic [8:0] last;
  logic [8:0] ref_sum;
  logic [7:0] ra;
  logic [7:0] rb;
  logic       rc;
  logic       rv;

  initial begin
    n_cmp = 0;
    n_bad = 0;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 9'h010};
    vecs[1] = '{8'h0F, 8'h0F, 1'b0, 9'h01E};
    vecs[2] = '{8'hF0, 8'h0F, 1'b0, 9'h0FF};
    vecs[3] = '{8'hAA, 8'h55, 1'b0, 9'h0FF};
    vecs[4] = '{8'hFF, 8'h01, 1'b1, 9'h101};
    vecs[5] = '{8'hFF, 8'h00, 1'b1, 9'h100};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 9'h000};

    // Reset asserted before any clock edge, with live operands.
    rst_n = 1'b0; A = 8'hA5; B = 8'h5A; Cin = 1'b1; in_valid = 1'b1;
    #2;
    check("reset_sum_noedge", {23'd0, Cout, S}, 32'h0);
    check("reset_valid_noedge", {31'd0, out_valid}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_sum_clocked", {23'd0, Cout, S}, 32'h0);

    // Release while idle: outputs remain clear.
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step(8'h12, 8'h34, 1'b1, 1'b0);
    check("idle_sum", {23'd0, Cout, S}, 32'h0);
    check("idle_valid", {31'd0, out_valid}, 32'h0);

    // Directed vectors, issued back to back.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
      check($sformatf("vec%0d_sum", i), {23'd0, Cout, S}, {23'd0, vecs[i].exp});
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'h1);
    end

    // Hold: last result retained when in_valid drops, whatever the operands.
    step(8'hFF, 8'h01, 1'b1, 1'b1);
    step(8'h33, 8'h44, 1'b0, 1'b0);
    check("hold_sum", {23'd0, Cout, S}, 32'h101);
    check("hold_valid", {31'd0, out_valid}, 32'h0);
    step(8'h01, 8'h01, 1'b0, 1'b0);
    check("hold2_sum", {23'd0, Cout, S}, 32'h101);

    // Mid-stream reset clears outputs without waiting for an edge.
    step(8'hC0, 8'h50, 1'b1, 1'b1);
    check("pre_rst_sum", {23'd0, Cout, S}, 32'h111);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_sum", {23'd0, Cout, S}, 32'h0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against A+B+Cin with hold-on-idle semantics.
    last = '0;
    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rv = ($urandom_range(0, 9) < 8);
      step(ra, rb, rc, rv);
      if (rv) begin
        ref_sum = 9'(ra) + 9'(rb) + 9'(rc);
        last = ref_sum;
      end
      check("rand_sum", {23'd0, Cout, S}, {23'd0, last});
      check("rand_valid", {31'd0, out_valid}, {31'd0, rv});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
